// File: rtl/pc_redirect_arbiter.sv
// ---------------------------------------------------------------------------
// PcRedirectArbiter (module pc_redirect_arbiter)
//
// This block is the only driver of the PC-generation redirect port. It takes
// redirect requests from three sources and picks one by fixed priority:
//   commit/exception (COMM) > branch-unit mispredict (BU) > early jump (EJ).
// The winner is stored in a one-entry redirect slot, which PC gen drains.
// After a COMM or BU redirect, any EJ requests that arrive in the next few
// cycles come from the wrong path, so they are consumed and dropped.
//
// Ports
//   clk_i           clock
//   rst_i           synchronous reset, active-high
//   comm_valid_i    commit redirect request (never back-pressured)
//   comm_target_i   commit redirect target
//   bu_valid_i      branch-unit redirect request
//   bu_ready_o      BU request accepted this cycle
//   bu_target_i     BU redirect target
//   ej_valid_i      early jump request
//   ej_ready_o      EJ request consumed this cycle (taken or squashed)
//   ej_base_i       early jump base (PC, or 0 for RET)
//   ej_offs_i       early jump offset (sign-extended imm, or ra)
//   ej_kill_o       pulse: EJ request squashed or EJ in slot preempted
//   pcgen_valid_o   redirect slot valid
//   pcgen_ready_i   PC gen takes the slot this cycle
//   pcgen_target_o  redirect target
//   pcgen_src_o     slot source: 00 none, 01 EJ, 10 BU, 11 COMM
// ---------------------------------------------------------------------------
module pc_redirect_arbiter #(
  parameter int unsigned XLEN          = 64,
  parameter int unsigned SQUASH_CYCLES = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,

  input  logic            comm_valid_i,
  input  logic [XLEN-1:0] comm_target_i,

  input  logic            bu_valid_i,
  output logic            bu_ready_o,
  input  logic [XLEN-1:0] bu_target_i,

  input  logic            ej_valid_i,
  output logic            ej_ready_o,
  input  logic [XLEN-1:0] ej_base_i,
  input  logic [XLEN-1:0] ej_offs_i,
  output logic            ej_kill_o,

  output logic            pcgen_valid_o,
  input  logic            pcgen_ready_i,
  output logic [XLEN-1:0] pcgen_target_o,
  output logic [1:0]      pcgen_src_o
);

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slotState_e;

  localparam logic [1:0] SRC_NONE = 2'b00;
  localparam logic [1:0] SRC_EJ   = 2'b01;
  localparam logic [1:0] SRC_BU   = 2'b10;
  localparam logic [1:0] SRC_COMM = 2'b11;

  // Instruction fetch addresses are at least 2-byte aligned, so bit 0 of a
  // computed jump target (e.g. an odd ra on RET) is always cleared.
  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-1){1'b1}}, 1'b0};

  slotState_e      slotState_q, slotState_d;
  logic [XLEN-1:0] slotTarget_q, slotTarget_d;
  logic [1:0]      slotSrc_q, slotSrc_d;

  logic            slotFree;
  logic            slotHoldsEj;
  logic            squashActive;
  logic            commAcc;
  logic            buReady;
  logic            buAcc;
  logic            ejReady;
  logic            ejAcc;
  logic            ejSquash;
  logic            preempt;
  logic [XLEN-1:0] ejTarget;

  assign ejTarget = (ej_base_i + ej_offs_i) & ALIGN_MASK;

  // The slot can take a new entry when empty or when it is drained this cycle.
  assign slotFree    = (slotState_q == SLOT_EMPTY) | pcgen_ready_i;
  assign slotHoldsEj = (slotState_q == SLOT_FULL) & (slotSrc_q == SRC_EJ);

  // All handshake outputs are gated by reset so nothing is accepted or
  // reported while the slot is being cleared, even if state is unknown.
  assign commAcc  = comm_valid_i & ~rst_i;
  assign buReady  = ~rst_i & ~comm_valid_i & (slotFree | slotHoldsEj);
  assign buAcc    = bu_valid_i & buReady;

  // While squashing, EJ is always consumed but never reaches the slot.
  assign ejReady  = ~rst_i & (squashActive |
                              (~comm_valid_i & ~bu_valid_i & slotFree));
  assign ejAcc    = ej_valid_i & ejReady & ~squashActive;
  assign ejSquash = ~rst_i & squashActive & ej_valid_i;

  // An EJ that PC gen has not taken yet is thrown away when a higher
  // priority redirect lands on top of it.
  assign preempt  = slotHoldsEj & ~pcgen_ready_i & (commAcc | buAcc);

  assign bu_ready_o = buReady;
  assign ej_ready_o = ejReady;
  assign ej_kill_o  = ~rst_i & (ejSquash | preempt);

  assign pcgen_valid_o  = (slotState_q == SLOT_FULL);
  assign pcgen_target_o = slotTarget_q;
  assign pcgen_src_o    = slotSrc_q;

  // Slot next state: an accept always (re)fills the slot with the winner in
  // priority order; otherwise a drain empties it and clears source/target.
  always_comb begin
    slotState_d  = slotState_q;
    slotTarget_d = slotTarget_q;
    slotSrc_d    = slotSrc_q;
    if (commAcc) begin
      slotState_d  = SLOT_FULL;
      slotTarget_d = comm_target_i;
      slotSrc_d    = SRC_COMM;
    end else if (buAcc) begin
      slotState_d  = SLOT_FULL;
      slotTarget_d = bu_target_i;
      slotSrc_d    = SRC_BU;
    end else if (ejAcc) begin
      slotState_d  = SLOT_FULL;
      slotTarget_d = ejTarget;
      slotSrc_d    = SRC_EJ;
    end else if ((slotState_q == SLOT_FULL) && pcgen_ready_i) begin
      slotState_d  = SLOT_EMPTY;
      slotTarget_d = '0;
      slotSrc_d    = SRC_NONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slotState_q  <= SLOT_EMPTY;
      slotTarget_q <= '0;
      slotSrc_q    <= SRC_NONE;
    end else begin
      slotState_q  <= slotState_d;
      slotTarget_q <= slotTarget_d;
      slotSrc_q    <= slotSrc_d;
    end
  end

  // Wrong-path squash window. With SQUASH_CYCLES=0 the window never opens
  // and no counter is built.
  if (SQUASH_CYCLES > 0) begin : gSquash
    localparam int unsigned CNT_W = $clog2(SQUASH_CYCLES + 1);

    logic [CNT_W-1:0] squashCnt_q, squashCnt_d;

    // A fresh COMM/BU redirect restarts the window even mid-countdown.
    always_comb begin
      squashCnt_d = squashCnt_q;
      if (commAcc | buAcc) begin
        squashCnt_d = CNT_W'(SQUASH_CYCLES);
      end else if (squashCnt_q != '0) begin
        squashCnt_d = squashCnt_q - CNT_W'(1);
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        squashCnt_q <= '0;
      end else begin
        squashCnt_q <= squashCnt_d;
      end
    end

    assign squashActive = (squashCnt_q != '0);
  end else begin : gNoSquash
    assign squashActive = 1'b0;
  end

endmodule
